// File: rtl/zsy_cnt_disp.sv
// Loadable BCD up/down counter with compare-reload terminal value,
// plus a multiplexed 7-segment scanner that shows the count one digit at a time.
module zsy_cnt_disp #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  CP,
    input  logic                  MR,
    input  logic                  LD,
    input  logic                  CE,
    input  logic                  DIR,
    input  logic [4*DIGITS-1:0]   Dn,
    input  logic [4*DIGITS-1:0]   DataB,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Dig
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] r_q;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_dig;
    logic [7:0]          r_seg;

    logic [4*DIGITS-1:0] w_next;
    logic                w_match;
    logic [3:0]          w_digval;
    logic [DIGITS-1:0]   w_dig_oh;

    // Digits of 9 and above (including non-BCD) roll to 0 and pass the carry on.
    function automatic logic [4*DIGITS-1:0] bcd_up(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        logic [3:0]          d;
        r = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (c) begin
                if (d >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Only a zero digit borrows; non-BCD digits simply step down by one.
    function automatic logic [4*DIGITS-1:0] bcd_dn(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                b;
        logic [3:0]          d;
        r = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (b) begin
                if (d == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = d - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    assign w_match = (r_q == DataB);

    always_comb begin
        w_next = r_q;
        if (LD) begin
            w_next = Dn;
        end else if (CE) begin
            if (w_match)  w_next = Dn;
            else if (DIR) w_next = bcd_up(r_q);
            else          w_next = bcd_dn(r_q);
        end
    end

    always_comb begin
        w_digval = 4'd0;
        w_dig_oh = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_digval    = r_q[4*k +: 4];
                w_dig_oh[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            r_q   <= '0;
            r_pre <= '0;
            r_idx <= '0;
            r_dig <= DIGITS'(1);
            r_seg <= 8'h3F;
        end else begin
            r_q   <= w_next;
            r_dig <= w_dig_oh;
            r_seg <= seg_decode(w_digval);
            if (r_pre == PW'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign Q   = r_q;
    assign TC  = CE & ~LD & w_match;
    assign Seg = r_seg;
    assign Dig = r_dig;

endmodule

// File: tb/tb_zsy_cnt_disp.sv
// Randomized and directed bench for zsy_cnt_disp (DIGITS=2, SCAN_DIV=4)
// against a decimal-arithmetic reference model.
module tb_zsy_cnt_disp;

    localparam int D  = 2;
    localparam int SD = 4;
    localparam int W  = 4 * D;

    logic         CP = 1'b0;
    logic         MR = 1'b0;
    logic         LD = 1'b0;
    logic         CE = 1'b0;
    logic         DIR = 1'b0;
    logic [W-1:0] Dn = '0;
    logic [W-1:0] DataB = '0;
    logic [W-1:0] Q;
    logic         TC;
    logic [7:0]   Seg;
    logic [D-1:0] Dig;

    zsy_cnt_disp #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .CP(CP), .MR(MR), .LD(LD), .CE(CE), .DIR(DIR),
        .Dn(Dn), .DataB(DataB), .Q(Q), .TC(TC), .Seg(Seg), .Dig(Dig)
    );

    always #5 CP = ~CP;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] segtab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic [W-1:0] m_q;
    int           m_cyc;
    logic [D-1:0] m_dig;
    logic [7:0]   m_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit all_bcd(input logic [W-1:0] v);
        for (int k = 0; k < D; k++) if (v[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] from_int(input int n);
        logic [W-1:0] r;
        int t = n;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int modulus();
        int m = 1;
        for (int k = 0; k < D; k++) m = m * 10;
        return m;
    endfunction

    // Pure decimal counting when all digits are BCD; digit rules otherwise.
    function automatic logic [W-1:0] step(input logic [W-1:0] v, input bit up);
        logic [W-1:0] r = v;
        int d;
        if (all_bcd(v)) begin
            if (up) return from_int((to_int(v) + 1) % modulus());
            return from_int((to_int(v) + modulus() - 1) % modulus());
        end
        for (int k = 0; k < D; k++) begin
            d = int'(v[4*k +: 4]);
            if (up) begin
                if (d >= 9) r[4*k +: 4] = 4'd0;
                else begin r[4*k +: 4] = 4'(d + 1); return r; end
            end else begin
                if (d == 0) r[4*k +: 4] = 4'd9;
                else begin r[4*k +: 4] = 4'(d - 1); return r; end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] m_next(input logic [W-1:0] q, input bit ld, ce, dir,
                                            input logic [W-1:0] dn, db);
        if (ld) return dn;
        if (!ce) return q;
        if (q == db) return dn;
        return step(q, dir);
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    // Entered and left just after a falling edge.
    task automatic cycle(input bit ld, ce, dir, input logic [W-1:0] dn, db);
        logic [W-1:0] nq;
        int idx;
        LD = ld; CE = ce; DIR = dir; Dn = dn; DataB = db;
        #1;
        chk("tc", 32'(TC), 32'(ce & ~ld & (m_q == db)));
        idx = (m_cyc / SD) % D;
        nq  = m_next(m_q, ld, ce, dir, dn, db);
        @(posedge CP); #1;
        m_dig = D'(1) << idx;
        m_seg = segtab[m_q[4*idx +: 4]];
        m_q   = nq;
        m_cyc++;
        chk("q", 32'(Q), 32'(m_q));
        chk("dig", 32'(Dig), 32'(m_dig));
        chk("seg", 32'(Seg), 32'(m_seg));
        @(negedge CP);
    endtask

    task automatic mr_pulse();
        #2 MR = 1'b1;
        #1;
        m_q = '0; m_cyc = 0; m_dig = D'(1); m_seg = 8'h3F;
        chk("rst_q", 32'(Q), 32'(0));
        chk("rst_dig", 32'(Dig), 32'(1));
        chk("rst_seg", 32'(Seg), 32'(8'h3F));
        chk("rst_tc", 32'(TC), 32'(CE & ~LD & (DataB == '0)));
        @(posedge CP); #1;
        chk("rst_hold_q", 32'(Q), 32'(0));
        chk("rst_hold_dig", 32'(Dig), 32'(1));
        @(negedge CP);
        MR = 1'b0;
    endtask

    initial begin
        logic [W-1:0] dn, db;
        bit ld, ce, dir;
        @(negedge CP);
        mr_pulse();

        // Full up-count through 99, then compare-reload to 00.
        for (int i = 0; i < 101; i++) cycle(0, 1, 1, 8'h00, 8'h99);

        // Terminal value 23 reloads 05.
        cycle(1, 0, 1, 8'h20, 8'h23);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 8'h05, 8'h23);

        // Down-count wrap, then a non-BCD low digit.
        cycle(1, 0, 0, 8'h00, 8'h50);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 8'h00, 8'h50);
        cycle(1, 0, 0, 8'h1F, 8'h50);
        cycle(0, 1, 0, 8'h1F, 8'h50);
        cycle(0, 1, 1, 8'h1F, 8'h50);

        // LD wins over compare with CE active, then MR mid-sequence.
        cycle(1, 0, 1, 8'h33, 8'h33);
        cycle(1, 1, 1, 8'h12, 8'h33);
        cycle(0, 1, 1, 8'h12, 8'h33);
        mr_pulse();

        // Held displays: 47 and A3 (blank high digit).
        cycle(1, 0, 1, 8'h47, 8'h99);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, 8'h00, 8'h99);
        cycle(1, 0, 1, 8'hA3, 8'h99);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 8'h00, 8'h99);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'h00, 8'h99);

        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(7) == 0);
            ce  = ($urandom_range(3) != 0);
            dir = 1'($urandom_range(1));
            dn  = ($urandom_range(7) == 0) ? W'($urandom) : rand_bcd();
            db  = ($urandom_range(2) == 0) ? m_q : rand_bcd();
            if ($urandom_range(99) == 0) mr_pulse();
            else cycle(ld, ce, dir, dn, db);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
